// File: rtl/alu_sin_deserializer.sv
// Serial front end of the ALU datapath. Receives 11-bit frames on sin
// (start, type, 8 payload bits MSB first, stop), collects 8 data bytes plus
// one control byte, and emits one decoded command or error per control frame.
module alu_sin_deserializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP,
    S_EVAL
  } state_t;

  // CRC4, polynomial x^4+x+1, init 0, message fed MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic            is_ctrl_q, is_ctrl_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0][7:0] buf_q, buf_d;

  logic            cmd_valid_q, cmd_valid_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            err_data_q, err_data_d;
  logic            err_crc_q, err_crc_d;
  logic            err_op_q, err_op_d;

  logic [31:0]     rx_a, rx_b;
  logic [2:0]      rx_op;
  logic            e_data, e_crc, e_op;

  // Operands as assembled from the byte buffer: bytes 0..3 are B, 4..7 are A.
  always_comb begin
    rx_b  = {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
    rx_a  = {buf_q[4], buf_q[5], buf_q[6], buf_q[7]};
    rx_op = shift_q[6:4];
  end

  // Command checks, only consumed in EVAL; priority data > crc > op.
  always_comb begin
    e_data = (byte_cnt_q != 4'd8) | frame_err_q | shift_q[7];
    e_crc  = !e_data & (crc4({rx_b, rx_a, 1'b1, rx_op}) != shift_q[3:0]);
    // Legal opcodes are 000, 001, 100, 101: exactly those with op[1] clear.
    e_op   = !e_data & !e_crc & rx_op[1];
  end

  // Receiver FSM next-state and output update logic.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | sin;
    is_ctrl_d   = is_ctrl_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    frame_err_d = frame_err_q;
    buf_d       = buf_q;
    cmd_valid_d = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    err_data_d  = err_data_q;
    err_crc_d   = err_crc_q;
    err_op_d    = err_op_q;

    case (state_q)
      S_IDLE: begin
        // A low line is a start bit only once a high sample has been seen.
        if (armed_q && !sin) state_d = S_TYPE;
      end
      S_TYPE: begin
        is_ctrl_d = sin;
        bit_cnt_d = 3'd0;
        state_d   = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        shift_d   = {shift_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        if (!sin) begin
          // Broken frame: remember it for the command and wait for the line
          // to return high before looking for another start bit.
          frame_err_d = 1'b1;
          armed_d     = 1'b0;
          state_d     = S_IDLE;
        end else if (is_ctrl_q) begin
          state_d = S_EVAL;
        end else begin
          // Bytes beyond the eighth are dropped; the count saturates at 9
          // so the command is still flagged.
          if (byte_cnt_q < 4'd8) buf_d[byte_cnt_q[2:0]] = shift_q;
          if (byte_cnt_q < 4'd9) byte_cnt_d = byte_cnt_q + 4'd1;
          state_d = S_IDLE;
        end
      end
      S_EVAL: begin
        cmd_valid_d = 1'b1;
        err_data_d  = e_data;
        err_crc_d   = e_crc;
        err_op_d    = e_op;
        if (!(e_data || e_crc || e_op)) begin
          a_d  = rx_a;
          b_d  = rx_b;
          op_d = rx_op;
        end
        byte_cnt_d  = 4'd0;
        frame_err_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      is_ctrl_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_cnt_q  <= 4'd0;
      frame_err_q <= 1'b0;
      buf_q       <= '0;
      cmd_valid_q <= 1'b0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      op_q        <= 3'b000;
      err_data_q  <= 1'b0;
      err_crc_q   <= 1'b0;
      err_op_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      is_ctrl_q   <= is_ctrl_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_err_q <= frame_err_d;
      buf_q       <= buf_d;
      cmd_valid_q <= cmd_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      err_data_q  <= err_data_d;
      err_crc_q   <= err_crc_d;
      err_op_q    <= err_op_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign err_data  = err_data_q;
  assign err_crc   = err_crc_q;
  assign err_op    = err_op_q;

endmodule

// File: tb/tb_alu_sin_deserializer.sv
// Bench for alu_sin_deserializer: a table of directed commands, a reset
// sequence, then random commands checked against a reference model.
module tb_alu_sin_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b0;
  logic        cmd_valid;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        err_data, err_crc, err_op;

  alu_sin_deserializer dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .cmd_valid(cmd_valid),
    .a(a), .b(b), .op(op),
    .err_data(err_data), .err_crc(err_crc), .err_op(err_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [2:0]  flags;   // {err_data, err_crc, err_op}
  } obs_t;
  obs_t obs_q[$];

  // Record every cycle in which cmd_valid is seen high.
  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      obs_t o;
      o.cyc = cyc; o.a = a; o.b = b; o.op = op;
      o.flags = {err_data, err_crc, err_op};
      obs_q.push_back(o);
    end
  end

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [3:0]  crcx;    // xor applied to the correct CRC
    int          nd;      // number of data frames
    int          bad;     // data frame index with stop bit 0, -1 for none
    bit          b7;      // control payload bit 7
    logic [2:0]  eflags;  // expected {err_data, err_crc, err_op}
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_a = 0, exp_b = 0;
  logic [2:0]  exp_op = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // CRC as the remainder of (message * x^4) divided by x^4+x+1 over GF(2).
  function automatic logic [3:0] crc_ref(input logic [31:0] bb, input logic [31:0] aa,
                                         input logic [2:0] oo);
    logic [71:0] m;
    m = {bb, aa, 1'b1, oo, 4'h0};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic logic [2:0] flags_ref(input int nd, input int bad, input bit b7,
                                           input logic [3:0] crcx, input logic [2:0] oo);
    bit d, c, o;
    d = (nd != 8) || (bad >= 0) || b7;
    c = !d && (crcx != 0);
    o = !d && !c && !(oo inside {3'b000, 3'b001, 3'b100, 3'b101});
    return {d, c, o};
  endfunction

  task automatic send_bit(input logic v);
    @(negedge clk);
    sin = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop,
                            output int start_cyc);
    send_bit(1'b0);
    start_cyc = cyc;
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
  endtask

  task automatic send_data(input logic [31:0] aa, input logic [31:0] bb, input int nd,
                           input int bad, input int gap);
    logic [7:0] byt;
    int         s;
    for (int i = 0; i < nd; i++) begin
      if (i < 4)      byt = bb[31 - 8*i -: 8];
      else if (i < 8) byt = aa[31 - 8*(i-4) -: 8];
      else            byt = 8'hA5;
      send_frame(1'b0, byt, (i != bad), s);
      idle((i == bad) ? 1 : gap);
    end
  endtask

  task automatic send_cmd(input logic [31:0] aa, input logic [31:0] bb, input logic [2:0] oo,
                          input logic [3:0] crcx, input int nd, input int bad, input bit b7,
                          input int gap, output int cs);
    send_data(aa, bb, nd, bad, gap);
    send_frame(1'b1, {b7, oo, crc_ref(bb, aa, oo) ^ crcx}, 1'b1, cs);
    idle(4);
  endtask

  // Compare the single expected cmd_valid pulse against the model.
  task automatic check_cmd(input string nm, input logic [31:0] aa, input logic [31:0] bb,
                           input logic [2:0] oo, input logic [2:0] ef, input int cs);
    obs_t o;
    if (ef == 3'b000) begin exp_a = aa; exp_b = bb; exp_op = oo; end
    chk({nm, " pulses"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      chk({nm, " latency"}, o.cyc - cs, 12);
      chk({nm, " flags"}, o.flags, ef);
      chk({nm, " a"}, o.a, exp_a);
      chk({nm, " b"}, o.b, exp_b);
      chk({nm, " op"}, o.op, exp_op);
    end
    obs_q.delete();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " cmd_valid"}, cmd_valid, 0);
    chk({nm, " a"}, a, 0);
    chk({nm, " b"}, b, 0);
    chk({nm, " op"}, op, 0);
    chk({nm, " flags"}, {err_data, err_crc, err_op}, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int cs, s;
    vec_t v;

    vecs.push_back('{"and",      32'h0000_00FF, 32'h0F0F_0F0F, 3'b000, 4'h0, 8, -1, 1'b0, 3'b000});
    vecs.push_back('{"crc_bad",  32'h0000_00FF, 32'h0F0F_0F0F, 3'b000, 4'h1, 8, -1, 1'b0, 3'b010});
    vecs.push_back('{"seven",    32'h1111_2222, 32'h3333_4444, 3'b001, 4'h0, 7, -1, 1'b0, 3'b100});
    vecs.push_back('{"nine",     32'h1111_2222, 32'h3333_4444, 3'b001, 4'h0, 9, -1, 1'b0, 3'b100});
    vecs.push_back('{"recover",  32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 4'h0, 8, -1, 1'b0, 3'b000});
    vecs.push_back('{"op010",    32'hCAFE_F00D, 32'hDEAD_BEEF, 3'b010, 4'h0, 8, -1, 1'b0, 3'b001});
    vecs.push_back('{"badstop",  32'h5555_AAAA, 32'hAAAA_5555, 3'b000, 4'h0, 8,  3, 1'b0, 3'b100});
    vecs.push_back('{"ctrl_b7",  32'h0000_0001, 32'h0000_0002, 3'b100, 4'h0, 8, -1, 1'b1, 3'b100});
    vecs.push_back('{"op100",    32'hFFFF_FFFF, 32'h0000_0000, 3'b100, 4'h0, 8, -1, 1'b0, 3'b000});
    vecs.push_back('{"op111",    32'h0BAD_0BAD, 32'h7777_7777, 3'b111, 4'h0, 8, -1, 1'b0, 3'b001});
    vecs.push_back('{"crc_op",   32'h0BAD_0BAD, 32'h7777_7777, 3'b111, 4'h8, 8, -1, 1'b0, 3'b010});

    // Reset with the line low, then release still low.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("post_reset");
    idle(2);

    foreach (vecs[i]) begin
      v = vecs[i];
      send_cmd(v.a, v.b, v.op, v.crcx, v.nd, v.bad, v.b7, 0, cs);
      check_cmd(v.name, v.a, v.b, v.op, v.eflags, cs);
    end

    // Reset in the middle of data byte 5, then a low line after release.
    send_data(32'h0101_0101, 32'h0202_0202, 5, -1, 0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    exp_a = 0; exp_b = 0; exp_op = 0;
    @(negedge clk);
    sin = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("spurious pulses", obs_q.size(), 0);
    obs_q.delete();
    idle(2);
    send_cmd(32'h0000_0005, 32'h0000_0009, 3'b101, 4'h0, 8, -1, 1'b0, 0, cs);
    check_cmd("sub_after_reset", 32'h0000_0005, 32'h0000_0009, 3'b101, 3'b000, cs);

    // Random commands against the reference model.
    for (int k = 0; k < 24; k++) begin
      logic [31:0] ra, rb;
      logic [2:0]  ro;
      logic [3:0]  rx;
      int          nd, bad, gap;
      bit          b7;
      ra  = $urandom;
      rb  = $urandom;
      ro  = 3'($urandom_range(0, 7));
      rx  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      nd  = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 7 : 9) : 8;
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nd - 1)) : -1;
      b7  = ($urandom_range(0, 11) == 0);
      gap = $urandom_range(0, 1);
      send_cmd(ra, rb, ro, rx, nd, bad, b7, gap, cs);
      check_cmd($sformatf("rand%0d", k), ra, rb, ro, flags_ref(nd, bad, b7, rx, ro), cs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_sin_deserializer.md
# alu_sin_deserializer

Serial-input front end of the ALU datapath. Receives the 11-bit framed byte stream on `sin`, assembles the two 32-bit operands and the control byte, and checks frame count, CRC4 and opcode. It presents one decoded command, or an error indication, per command to the ALU core. Sits directly upstream of the ALU core and result serializer; `op` uses the shared `operation_t` encoding from `alu_pkg`.

## Interface
- No parameters.
- `clk`  in  1  system clock; `sin` sampled on rising edge, one bit per cycle.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sin`  in  1  serial input, idle high.
- `cmd_valid`  out  1  one-cycle pulse: `a`, `b`, `op` and the error flags are valid.
- `a`  out  32  operand A.
- `b`  out  32  operand B.
- `op`  out  3  opcode (`operation_t`).
- `err_data`  out  1  frame-count or framing error.
- `err_crc`  out  1  CRC4 mismatch.
- `err_op`  out  1  unknown opcode.

## Operation
- Frame format, in order: start bit `0`, type bit (`0` = data, `1` = control), 8 payload bits MSB first, stop bit `1`.
- A command is 8 data frames followed by 1 control frame.
  - Data bytes 0..3 are B[31:24]..B[7:0].
  - Data bytes 4..7 are A[31:24]..A[7:0].
  - Control payload is {1'b0, op[2:0], crc[3:0]}.
- FSM states: IDLE, TYPE, PAYLOAD, STOP, EVAL.
  - IDLE→TYPE when armed and `sin`=0.
  - TYPE→PAYLOAD: latch the type bit; clear the bit counter.
  - PAYLOAD: shift `sin` in; after 8 bits → STOP.
  - STOP, `sin`=1, data frame: store the byte at `byte_cnt`, increment `byte_cnt`, → IDLE.
  - STOP, `sin`=1, control frame: → EVAL.
  - STOP, `sin`=0: set the sticky `frame_err`, → IDLE. The next high sample re-arms the receiver.
  - EVAL: compute flags, pulse `cmd_valid`, clear `byte_cnt` and `frame_err`, → IDLE.
- Arming: after reset the receiver is disarmed. It arms on the first sample of `sin`=1, so a line held low at reset release is not taken as a start bit.
- `byte_cnt` is 4 bits and saturates at 9. A data frame arriving with `byte_cnt`≥8 is discarded, and the command is flagged `err_data`.
- Error flags, evaluated in EVAL:
  - `err_data` = (`byte_cnt` != 8) | `frame_err` | control payload bit 7 set.
  - `err_crc` = !`err_data` & (CRC4 over {B, A, 1'b1, op}, 68 bits MSB first, polynomial x^4+x+1, init 0, != crc).
  - `err_op` = !`err_data` & !`err_crc` & op ∉ {000, 001, 100, 101}.
  - At most one flag is set per command. Priority: data > crc > op.
- Output updates:
  - With no error, `a`, `b` and `op` update at `cmd_valid`.
  - With any error, `a`, `b` and `op` hold their previous values and only the flags update.
  - All outputs except `cmd_valid` hold until the next `cmd_valid`.

## Timing
- Reset values: `cmd_valid`=0, `a`=0, `b`=0, `op`=3'b000, all error flags 0. Reset also clears FSM→IDLE, disarmed, `byte_cnt`=0, `frame_err`=0.
- A frame occupies exactly 11 cycles.
- Back-to-back frames are supported: a start bit may be sampled in the cycle immediately after a stop bit.
- `cmd_valid` goes high in the cycle after the control frame's stop bit is sampled (EVAL) and lasts exactly one cycle.
- Latency from the control start bit to `cmd_valid` is 12 cycles. The receiver is in IDLE and can accept a start bit in the cycle after EVAL.
- Reset asserted mid-frame or mid-command: partial data is discarded and no `cmd_valid` is produced.
- There is no timeout: a partial command waits indefinitely for its control frame.

## Test plan
- AND command: A=0x0000_00FF, B=0x0F0F_0F0F, op=000, correct CRC → `cmd_valid` 12 cycles after the control start bit; `a`=0x000000FF, `b`=0x0F0F0F0F, `op`=000, all flags 0.
- Same command with the transmitted CRC replaced by (correct CRC ^ 4'h1) → `err_crc`=1, other flags 0; `a`, `b`, `op` unchanged from the previous command.
- 7 data frames then a valid control frame → `err_data`=1.
- 9 data frames then a control frame → `err_data`=1.
- A following correct 8+1 command → clean decode with flags 0 (proves the counter clears).
- op=010 with CRC correct for 010 → `err_op`=1, `err_crc`=0, `err_data`=0.
- Stop bit forced to 0 in data byte 3 → `err_data`=1 at the control frame.
- `rst_n` pulsed low during data byte 5, then `sin` held low for 3 cycles after release, then a full valid SUB command (op=101) → no spurious start bit, one `cmd_valid` with flags 0; all outputs 0 while in reset.
